// File: rtl/inspecao_qualidade_fila.sv
// rtl/inspecao_qualidade_fila.sv - bottle inspection queue with operator/timeout decision and counters
module inspecao_qualidade_fila #(
    parameter int FILA_PROF = 4,
    parameter int ID_W      = 4,
    parameter int CONT_W    = 8,
    parameter int TIMEOUT   = 100
) (
    input  logic                           CLOCK,
    input  logic                           RESET_N,
    input  logic                           GARRAFA_VEDADA,
    input  logic [ID_W-1:0]                GARRAFA_ID,
    input  logic                           PULSO_APROVADA,
    input  logic                           PULSO_REPROVADA,
    input  logic                           LIMPA_CONTADORES,
    output logic                           LACRE,
    output logic                           DESCARTE,
    output logic                           DESCARTE_TIMEOUT,
    output logic [ID_W-1:0]                ID_SAIDA,
    output logic                           EM_INSPECAO,
    output logic [$clog2(FILA_PROF+1)-1:0] FILA_NIVEL,
    output logic                           FILA_CHEIA,
    output logic                           ERRO_OVERFLOW,
    output logic [CONT_W-1:0]              CONT_APROVADAS,
    output logic [CONT_W-1:0]              CONT_REPROVADAS
);

    localparam int PTR_W = $clog2(FILA_PROF);
    localparam int NIV_W = $clog2(FILA_PROF+1);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic {
        OCIOSO,
        INSPECIONANDO
    } estado_t;

    estado_t               r_estado;
    logic [TMR_W-1:0]      r_timer;
    logic [ID_W-1:0]       r_mem [FILA_PROF];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [NIV_W-1:0]      r_nivel;
    logic                  r_cheia;
    logic                  r_overflow;
    logic                  r_lacre;
    logic                  r_descarte;
    logic                  r_descarte_tmo;
    logic [ID_W-1:0]       r_id_saida;
    logic                  r_em_inspecao;
    logic [CONT_W-1:0]     r_cont_apr;
    logic [CONT_W-1:0]     r_cont_rep;

    logic                  w_inspecionando;
    logic                  w_aprova;
    logic                  w_reprova;
    logic                  w_timeout;
    logic                  w_pop;
    logic                  w_cheio;
    logic                  w_push;
    logic                  w_drop;
    logic [NIV_W-1:0]      w_nivel_prox;

    assign w_inspecionando = (r_estado == INSPECIONANDO);
    // Conflicting pulses (both high) count as no decision at all.
    assign w_aprova  = w_inspecionando &&  PULSO_APROVADA && !PULSO_REPROVADA;
    assign w_reprova = w_inspecionando && !PULSO_APROVADA &&  PULSO_REPROVADA;
    // A valid operator decision on the last cycle beats the timeout.
    assign w_timeout = w_inspecionando && (r_timer == TMR_W'(TIMEOUT-1)) && !w_aprova && !w_reprova;
    assign w_pop     = w_aprova || w_reprova || w_timeout;
    assign w_cheio   = (r_nivel == NIV_W'(FILA_PROF));
    // A full queue still accepts a bottle when the head leaves in the same cycle.
    assign w_push    = GARRAFA_VEDADA && (!w_cheio || w_pop);
    assign w_drop    = GARRAFA_VEDADA && w_cheio && !w_pop;

    // Next queue level from the push/pop pair.
    always_comb begin
        w_nivel_prox = r_nivel;
        case ({w_push, w_pop})
            2'b10:   w_nivel_prox = r_nivel + NIV_W'(1);
            2'b01:   w_nivel_prox = r_nivel - NIV_W'(1);
            default: w_nivel_prox = r_nivel;
        endcase
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= GARRAFA_ID;
        end
    end

    // Pointers, level, full flag and sticky overflow.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_nivel    <= '0;
            r_cheia    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_nivel <= w_nivel_prox;
            r_cheia <= (w_nivel_prox == NIV_W'(FILA_PROF));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Inspection FSM with timer and registered decision outputs.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_estado       <= OCIOSO;
            r_timer        <= '0;
            r_lacre        <= 1'b0;
            r_descarte     <= 1'b0;
            r_descarte_tmo <= 1'b0;
            r_id_saida     <= '0;
            r_em_inspecao  <= 1'b0;
        end else begin
            r_lacre        <= 1'b0;
            r_descarte     <= 1'b0;
            r_descarte_tmo <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (r_nivel != '0) begin
                        r_estado      <= INSPECIONANDO;
                        r_timer       <= '0;
                        r_em_inspecao <= 1'b1;
                    end
                end
                INSPECIONANDO: begin
                    if (w_pop) begin
                        r_lacre        <= w_aprova;
                        r_descarte     <= w_reprova || w_timeout;
                        r_descarte_tmo <= w_timeout;
                        r_id_saida     <= r_mem[r_rd_ptr];
                        r_estado       <= OCIOSO;
                        r_em_inspecao  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_estado      <= OCIOSO;
                    r_em_inspecao <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cont_apr <= '0;
            r_cont_rep <= '0;
        end else if (LIMPA_CONTADORES) begin
            r_cont_apr <= '0;
            r_cont_rep <= '0;
        end else begin
            if (w_aprova && (r_cont_apr != {CONT_W{1'b1}})) begin
                r_cont_apr <= r_cont_apr + CONT_W'(1);
            end
            if ((w_reprova || w_timeout) && (r_cont_rep != {CONT_W{1'b1}})) begin
                r_cont_rep <= r_cont_rep + CONT_W'(1);
            end
        end
    end

    assign LACRE            = r_lacre;
    assign DESCARTE         = r_descarte;
    assign DESCARTE_TIMEOUT = r_descarte_tmo;
    assign ID_SAIDA         = r_id_saida;
    assign EM_INSPECAO      = r_em_inspecao;
    assign FILA_NIVEL       = r_nivel;
    assign FILA_CHEIA       = r_cheia;
    assign ERRO_OVERFLOW    = r_overflow;
    assign CONT_APROVADAS   = r_cont_apr;
    assign CONT_REPROVADAS  = r_cont_rep;

endmodule

// File: tb/tb_inspecao_qualidade_fila.sv
// tb/tb_inspecao_qualidade_fila.sv - self-checking bench for inspecao_qualidade_fila
module tb_inspecao_qualidade_fila;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       GARRAFA_VEDADA = 1'b0;
    logic [3:0] GARRAFA_ID = '0;
    logic       PULSO_APROVADA = 1'b0;
    logic       PULSO_REPROVADA = 1'b0;
    logic       LIMPA_CONTADORES = 1'b0;
    logic       LACRE;
    logic       DESCARTE;
    logic       DESCARTE_TIMEOUT;
    logic [3:0] ID_SAIDA;
    logic       EM_INSPECAO;
    logic [2:0] FILA_NIVEL;
    logic       FILA_CHEIA;
    logic       ERRO_OVERFLOW;
    logic [1:0] CONT_APROVADAS;
    logic [1:0] CONT_REPROVADAS;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       lacre;
        logic [3:0] id;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    inspecao_qualidade_fila #(
        .FILA_PROF(4),
        .ID_W(4),
        .CONT_W(2),
        .TIMEOUT(100)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .GARRAFA_VEDADA(GARRAFA_VEDADA),
        .GARRAFA_ID(GARRAFA_ID),
        .PULSO_APROVADA(PULSO_APROVADA),
        .PULSO_REPROVADA(PULSO_REPROVADA),
        .LIMPA_CONTADORES(LIMPA_CONTADORES),
        .LACRE(LACRE),
        .DESCARTE(DESCARTE),
        .DESCARTE_TIMEOUT(DESCARTE_TIMEOUT),
        .ID_SAIDA(ID_SAIDA),
        .EM_INSPECAO(EM_INSPECAO),
        .FILA_NIVEL(FILA_NIVEL),
        .FILA_CHEIA(FILA_CHEIA),
        .ERRO_OVERFLOW(ERRO_OVERFLOW),
        .CONT_APROVADAS(CONT_APROVADAS),
        .CONT_REPROVADAS(CONT_REPROVADAS)
    );

    always #5 CLOCK = ~CLOCK;

    // Scoreboard: every output pulse must match the oldest expected decision.
    always @(negedge CLOCK) begin
        if (LACRE === 1'b1 || DESCARTE === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: LACRE=%b DESCARTE=%b ID_SAIDA=%0d, required no pulse", LACRE, DESCARTE, ID_SAIDA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({LACRE, DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA} !== {e.lacre, ~e.lacre, e.tmo, e.id}) begin
                    n_errors++;
                    $display("FAIL sb_pulse: got L=%b D=%b T=%b id=%0d, required L=%b D=%b T=%b id=%0d",
                             LACRE, DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, e.lacre, ~e.lacre, e.tmo, e.id);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic aplica_reset();
        GARRAFA_VEDADA = 0; PULSO_APROVADA = 0; PULSO_REPROVADA = 0; LIMPA_CONTADORES = 0;
        RESET_N = 0;
        @(negedge CLOCK);
        RESET_N = 1;
    endtask

    task automatic empurra(input logic [3:0] id);
        GARRAFA_VEDADA = 1; GARRAFA_ID = id;
        @(negedge CLOCK);
        GARRAFA_VEDADA = 0;
    endtask

    task automatic aguarda_inspecao();
        int k;
        k = 0;
        while (EM_INSPECAO !== 1'b1 && k < 20) begin
            @(negedge CLOCK);
            k++;
        end
        n_checks++;
        if (EM_INSPECAO !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_insp: EM_INSPECAO=%b, required 1 within 20 cycles", EM_INSPECAO);
        end
    endtask

    task automatic decidir(input logic aprova, input logic [3:0] id, input logic [1:0] ca,
                           input logic [1:0] cr, input logic [2:0] niv);
        sb.push_back('{lacre: aprova, id: id, tmo: 1'b0});
        PULSO_APROVADA = aprova; PULSO_REPROVADA = ~aprova;
        @(negedge CLOCK);
        PULSO_APROVADA = 0; PULSO_REPROVADA = 0;
        n_checks++;
        if ({LACRE, DESCARTE, DESCARTE_TIMEOUT, EM_INSPECAO, FILA_NIVEL} !== {aprova, ~aprova, 1'b0, 1'b0, niv}) begin
            n_errors++;
            $display("FAIL decide_t1(id %0d): L=%b D=%b T=%b EM=%b niv=%0d, required L=%b D=%b T=0 EM=0 niv=%0d",
                     id, LACRE, DESCARTE, DESCARTE_TIMEOUT, EM_INSPECAO, FILA_NIVEL, aprova, ~aprova, niv);
        end
        n_checks++;
        if ({CONT_APROVADAS, CONT_REPROVADAS} !== {ca, cr}) begin
            n_errors++;
            $display("FAIL counters(id %0d): apr=%0d rep=%0d, required apr=%0d rep=%0d", id, CONT_APROVADAS, CONT_REPROVADAS, ca, cr);
        end
        @(negedge CLOCK);
        n_checks++;
        if ({LACRE, DESCARTE, EM_INSPECAO} !== {1'b0, 1'b0, (niv != 0)}) begin
            n_errors++;
            $display("FAIL decide_t2(id %0d): L=%b D=%b EM=%b, required L=0 D=0 EM=%b", id, LACRE, DESCARTE, EM_INSPECAO, (niv != 0));
        end
    endtask

    task automatic test_reset();
        RESET_N = 0;
        repeat (2) @(negedge CLOCK);
        n_checks++;
        if ({LACRE, DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, EM_INSPECAO, FILA_NIVEL, FILA_CHEIA,
             ERRO_OVERFLOW, CONT_APROVADAS, CONT_REPROVADAS} !== 19'd0) begin
            n_errors++;
            $display("FAIL reset_state: outputs=%b, required all 0",
                     {LACRE, DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, EM_INSPECAO, FILA_NIVEL, FILA_CHEIA,
                      ERRO_OVERFLOW, CONT_APROVADAS, CONT_REPROVADAS});
        end
        RESET_N = 1;
        @(negedge CLOCK);
    endtask

    task automatic test_sequencia();
        empurra(4'd3);
        n_checks++;
        if ({FILA_NIVEL, EM_INSPECAO} !== {3'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL seq_first_push: niv=%0d EM=%b, required niv=1 EM=0", FILA_NIVEL, EM_INSPECAO);
        end
        empurra(4'd5);
        n_checks++;
        if (EM_INSPECAO !== 1'b1) begin
            n_errors++;
            $display("FAIL seq_em_t2: EM=%b, required 1", EM_INSPECAO);
        end
        empurra(4'd7);
        n_checks++;
        if (FILA_NIVEL !== 3'd3) begin
            n_errors++;
            $display("FAIL seq_level3: niv=%0d, required 3", FILA_NIVEL);
        end
        aguarda_inspecao(); decidir(1'b1, 4'd3, 2'd1, 2'd0, 3'd2);
        aguarda_inspecao(); decidir(1'b0, 4'd5, 2'd1, 2'd1, 3'd1);
        aguarda_inspecao(); decidir(1'b1, 4'd7, 2'd2, 2'd1, 3'd0);
    endtask

    task automatic test_timeout();
        int cnt;
        aplica_reset();
        empurra(4'd9);
        aguarda_inspecao();
        sb.push_back('{lacre: 1'b0, id: 4'd9, tmo: 1'b1});
        cnt = 0;
        while (EM_INSPECAO === 1'b1 && cnt < 150) begin
            cnt++;
            @(negedge CLOCK);
        end
        n_checks++;
        if (cnt != 100) begin
            n_errors++;
            $display("FAIL timeout_len: EM_INSPECAO high %0d cycles, required 100", cnt);
        end
        n_checks++;
        if ({DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, CONT_REPROVADAS, LACRE} !== {1'b1, 1'b1, 4'd9, 2'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL timeout_pulse: D=%b T=%b id=%0d rep=%0d L=%b, required D=1 T=1 id=9 rep=1 L=0",
                     DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, CONT_REPROVADAS, LACRE);
        end
        @(negedge CLOCK);
    endtask

    task automatic test_conflito();
        empurra(4'd10);
        aguarda_inspecao();
        PULSO_APROVADA = 1; PULSO_REPROVADA = 1;
        @(negedge CLOCK);
        PULSO_APROVADA = 0; PULSO_REPROVADA = 0;
        n_checks++;
        if ({LACRE, DESCARTE, EM_INSPECAO} !== 3'b001) begin
            n_errors++;
            $display("FAIL conflict: L=%b D=%b EM=%b, required L=0 D=0 EM=1", LACRE, DESCARTE, EM_INSPECAO);
        end
        decidir(1'b1, 4'd10, 2'd1, 2'd1, 3'd0);
    endtask

    task automatic test_overflow();
        aplica_reset();
        empurra(4'd1); empurra(4'd2); empurra(4'd3); empurra(4'd4);
        n_checks++;
        if ({FILA_CHEIA, FILA_NIVEL, ERRO_OVERFLOW} !== {1'b1, 3'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL ovf_full: cheia=%b niv=%0d ovf=%b, required cheia=1 niv=4 ovf=0", FILA_CHEIA, FILA_NIVEL, ERRO_OVERFLOW);
        end
        empurra(4'd5);
        n_checks++;
        if ({ERRO_OVERFLOW, FILA_NIVEL} !== {1'b1, 3'd4}) begin
            n_errors++;
            $display("FAIL ovf_drop: ovf=%b niv=%0d, required ovf=1 niv=4", ERRO_OVERFLOW, FILA_NIVEL);
        end
        aguarda_inspecao();
        sb.push_back('{lacre: 1'b1, id: 4'd1, tmo: 1'b0});
        GARRAFA_VEDADA = 1; GARRAFA_ID = 4'd6; PULSO_APROVADA = 1;
        @(negedge CLOCK);
        GARRAFA_VEDADA = 0; PULSO_APROVADA = 0;
        n_checks++;
        if ({LACRE, FILA_NIVEL, FILA_CHEIA} !== {1'b1, 3'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL ovf_push_pop: L=%b niv=%0d cheia=%b, required L=1 niv=4 cheia=1", LACRE, FILA_NIVEL, FILA_CHEIA);
        end
        aguarda_inspecao(); decidir(1'b1, 4'd2, 2'd2, 2'd0, 3'd3);
        aguarda_inspecao(); decidir(1'b0, 4'd3, 2'd2, 2'd1, 3'd2);
        aguarda_inspecao(); decidir(1'b1, 4'd4, 2'd3, 2'd1, 3'd1);
        aguarda_inspecao(); decidir(1'b1, 4'd6, 2'd3, 2'd1, 3'd0);
        n_checks++;
        if (ERRO_OVERFLOW !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", ERRO_OVERFLOW);
        end
    endtask

    task automatic test_saturacao();
        logic [1:0] ca;
        aplica_reset();
        for (int i = 1; i <= 5; i++) begin
            ca = (i > 3) ? 2'd3 : 2'(i);
            empurra(4'(i));
            aguarda_inspecao();
            decidir(1'b1, 4'(i), ca, 2'd0, 3'd0);
        end
        empurra(4'd12);
        aguarda_inspecao();
        sb.push_back('{lacre: 1'b1, id: 4'd12, tmo: 1'b0});
        PULSO_APROVADA = 1; LIMPA_CONTADORES = 1;
        @(negedge CLOCK);
        PULSO_APROVADA = 0; LIMPA_CONTADORES = 0;
        n_checks++;
        if ({LACRE, CONT_APROVADAS, CONT_REPROVADAS} !== {1'b1, 2'd0, 2'd0}) begin
            n_errors++;
            $display("FAIL clear_vs_inc: L=%b apr=%0d rep=%0d, required L=1 apr=0 rep=0", LACRE, CONT_APROVADAS, CONT_REPROVADAS);
        end
        @(negedge CLOCK);
    endtask

    task automatic test_reset_meio();
        aplica_reset();
        empurra(4'd2); empurra(4'd4);
        aguarda_inspecao();
        n_checks++;
        if (FILA_NIVEL !== 3'd2) begin
            n_errors++;
            $display("FAIL rstmid_level: niv=%0d, required 2", FILA_NIVEL);
        end
        #2 RESET_N = 0;
        #1;
        n_checks++;
        if ({LACRE, DESCARTE, DESCARTE_TIMEOUT, ID_SAIDA, EM_INSPECAO, FILA_NIVEL, FILA_CHEIA,
             ERRO_OVERFLOW, CONT_APROVADAS, CONT_REPROVADAS} !== 19'd0) begin
            n_errors++;
            $display("FAIL rstmid_async: EM=%b niv=%0d L=%b D=%b, required all outputs 0", EM_INSPECAO, FILA_NIVEL, LACRE, DESCARTE);
        end
        @(negedge CLOCK);
        RESET_N = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK);
            n_checks++;
            if ({LACRE, DESCARTE, EM_INSPECAO} !== 3'b000) begin
                n_errors++;
                $display("FAIL rstmid_quiet: L=%b D=%b EM=%b, required 0 0 0", LACRE, DESCARTE, EM_INSPECAO);
            end
        end
        empurra(4'd8);
        n_checks++;
        if ({FILA_NIVEL, EM_INSPECAO} !== {3'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL rstmid_push_t1: niv=%0d EM=%b, required niv=1 EM=0", FILA_NIVEL, EM_INSPECAO);
        end
        @(negedge CLOCK);
        n_checks++;
        if (EM_INSPECAO !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_push_t2: EM=%b, required 1", EM_INSPECAO);
        end
        decidir(1'b1, 4'd8, 2'd1, 2'd0, 3'd0);
    endtask

    initial begin
        test_reset();
        test_sequencia();
        test_timeout();
        test_conflito();
        test_overflow();
        test_saturacao();
        test_reset_meio();
        repeat (3) @(negedge CLOCK);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inspecao_qualidade_fila.md
# inspecao_qualidade_fila

Parametrised quality-inspection stage for the bottling line, placed after sealing and before the seal/reject actuators. Sealed bottles are queued by ID in a FIFO of configurable depth and inspected one at a time, head first. Each bottle receives an operator approve/reject decision, or an automatic reject on decision timeout. Saturating approved/rejected counters and a sticky overflow flag are kept for the line display.

## Interface
Parameters:
- FILA_PROF, 4: queue depth in bottles (≥2, power of two).
- ID_W, 4: bottle ID width.
- CONT_W, 8: width of each statistics counter.
- TIMEOUT, 100: cycles allowed in INSPECIONANDO before automatic reject (≥2). Timer width is $clog2(TIMEOUT).

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- GARRAFA_VEDADA  in  1  one-cycle pulse: sealed bottle enters the queue.
- GARRAFA_ID  in  ID_W  ID of the entering bottle, sampled with GARRAFA_VEDADA.
- PULSO_APROVADA  in  1  one-cycle operator approve pulse, debounced upstream.
- PULSO_REPROVADA  in  1  one-cycle operator reject pulse, debounced upstream.
- LIMPA_CONTADORES  in  1  synchronous clear of both counters.
- LACRE  out  1  one-cycle approve pulse.
- DESCARTE  out  1  one-cycle reject pulse.
- DESCARTE_TIMEOUT  out  1  high together with DESCARTE when the reject was caused by timeout.
- ID_SAIDA  out  ID_W  ID of the decided bottle. Valid with LACRE or DESCARTE, holds otherwise.
- EM_INSPECAO  out  1  state == INSPECIONANDO.
- FILA_NIVEL  out  $clog2(FILA_PROF+1)  bottles queued, including the one under inspection.
- FILA_CHEIA  out  1  FILA_NIVEL == FILA_PROF. Used as a stall to the conveyor.
- ERRO_OVERFLOW  out  1  sticky; set when a bottle was dropped.
- CONT_APROVADAS  out  CONT_W  saturating approved count.
- CONT_REPROVADAS  out  CONT_W  saturating rejected count (manual and timeout).

## Operation
- Reset (RESET_N low, asynchronous):
  - All outputs 0, queue empty, state OCIOSO, timer 0, ERRO_OVERFLOW cleared.
- Enqueue: GARRAFA_VEDADA=1 writes GARRAFA_ID at the tail.
  - If the queue is full and no pop occurs in the same cycle, the bottle is dropped and ERRO_OVERFLOW is set. It stays set until reset.
  - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
- FSM states:
  - OCIOSO: decision pulses are ignored. Go to INSPECIONANDO when FILA_NIVEL > 0. The timer clears on entry to INSPECIONANDO.
  - INSPECIONANDO: the head bottle is under inspection and the timer increments every cycle.
    - Approve (PULSO_APROVADA & !PULSO_REPROVADA): LACRE.
    - Reject (PULSO_REPROVADA & !PULSO_APROVADA): DESCARTE.
    - Both pulses high: conflict. Ignored, the timer keeps running.
    - Timer == TIMEOUT-1 with no valid decision: DESCARTE plus DESCARTE_TIMEOUT.
    - A valid decision on the timeout cycle takes priority over the timeout.
    - Any decision pops the head, loads its ID into ID_SAIDA, and returns the FSM to OCIOSO.
- Counters:
  - CONT_APROVADAS increments on LACRE; CONT_REPROVADAS increments on DESCARTE.
  - Both saturate at 2^CONT_W−1.
  - LIMPA_CONTADORES zeroes both and overrides an increment in the same cycle. Queue and FSM are unaffected.
- Pointers wrap modulo FILA_PROF. Order is strictly FIFO.

## Timing
- All outputs are registered.
- Decision pulse at cycle t, in INSPECIONANDO:
  - At t+1: LACRE or DESCARTE high for exactly one cycle, ID_SAIDA valid, counters updated, FILA_NIVEL decremented, EM_INSPECAO low.
  - At t+2: EM_INSPECAO high again if FILA_NIVEL > 0. Minimum spacing between decisions is 2 cycles.
- Enqueue at t into an empty queue: FILA_NIVEL=1 at t+1, EM_INSPECAO=1 at t+2.
- Timeout: EM_INSPECAO high for exactly TIMEOUT cycles, then DESCARTE and DESCARTE_TIMEOUT on the next cycle.
- Reset asserted mid-inspection: outputs go to 0 immediately and no pulse is emitted. After release, the first push follows the empty-queue timing.

## Test plan
- Reset, push IDs 3,5,7, approve, reject, approve:
  - LACRE ID 3, DESCARTE ID 5, LACRE ID 7, each one cycle after its pulse.
  - Counters end at 2/1. FILA_NIVEL steps 3→0.
- Push ID 9, no decision, TIMEOUT=100:
  - EM_INSPECAO high for 100 cycles.
  - Then DESCARTE=1, DESCARTE_TIMEOUT=1, ID_SAIDA=9, CONT_REPROVADAS=1.
- Both pulses high in the same cycle during inspection:
  - No LACRE or DESCARTE, state stays INSPECIONANDO.
  - A following approve pulse gives LACRE.
- FILA_PROF=4, push 5 bottles with no decisions:
  - FILA_CHEIA=1 after the 4th push.
  - 5th push dropped, ERRO_OVERFLOW=1, FILA_NIVEL=4.
  - Push together with approve while full: accepted, FILA_NIVEL stays 4.
- CONT_W=2, approve 5 bottles:
  - CONT_APROVADAS saturates at 3.
  - LIMPA_CONTADORES in the same cycle as a LACRE gives 0.
- Drive RESET_N low during INSPECIONANDO with 2 bottles queued:
  - All outputs 0 asynchronously, FILA_NIVEL=0, no stray LACRE after release.
